// File: rtl/seven_seg_scroll_scheduler_if.sv
// Character stream that carries segment patterns into the scroll scheduler.
// The source drives the master side and the scheduler takes the slave side.
interface seven_seg_scroll_scheduler_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_data;
  logic       msg_last;

  modport master (output msg_valid, output msg_data, output msg_last, input msg_ready);
  modport slave  (input msg_valid, input msg_data, input msg_last, output msg_ready);
endinterface

// File: rtl/seven_seg_scroll_scheduler.sv
// Buffers a message of segment patterns, then multiplexes it onto a 4-digit
// display and scrolls it left with wrap-around when it is wider than the display.
module seven_seg_scroll_scheduler #(
  parameter int SCAN_DIV_W    = 17,
  parameter int SCROLL_FRAMES = 64,
  parameter int MSG_MAX       = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  seven_seg_scroll_scheduler_if.slave       msg,
  input  logic                              scroll_en,
  input  logic                              clear,
  output logic [7:0]                        abcdefgh,
  output logic [3:0]                        digit,
  output logic                              busy
);
  localparam int PTR_W = $clog2(MSG_MAX);
  localparam int LEN_W = PTR_W + 1;
  localparam int FC_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
  state_t state, state_next;

  logic [SCAN_DIV_W-1:0] div_cnt;
  logic [3:0]            scan;
  logic [FC_W-1:0]       frame_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      offset;
  logic [LEN_W-1:0]      len;
  logic [7:0]            msg_buf [MSG_MAX];

  logic             ready;
  logic             scan_tick, frame_end, scroll_step;
  logic             accept, load_done;
  logic [PTR_W-1:0] wr_idx;
  logic [1:0]       pos;
  logic [LEN_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;

  assign msg.msg_ready = ready;
  assign scan_tick     = (div_cnt == '0);
  assign frame_end     = scan_tick && (scan == 4'b0001);
  assign scroll_step   = frame_end && (frame_cnt == FC_W'(SCROLL_FRAMES - 1));
  // clear wins over a simultaneous handshake, so the beat is dropped
  assign accept        = msg.msg_valid && ready && !clear;
  assign load_done     = accept && (state == LOAD) &&
                         (msg.msg_last || (wr_ptr == PTR_W'(MSG_MAX - 1)));
  assign wr_idx        = (state == IDLE) ? '0 : wr_ptr;

  always_comb begin
    case (scan)
      4'b1000: pos = 2'd0;
      4'b0100: pos = 2'd1;
      4'b0010: pos = 2'd2;
      default: pos = 2'd3;
    endcase
  end

  // offset < len and pos < len whenever scrolling, so one subtraction wraps the index
  assign idx_sum = (LEN_W + 1)'(offset) + (LEN_W + 1)'(pos);
  assign idx     = (idx_sum >= {1'b0, len}) ? PTR_W'(idx_sum - {1'b0, len}) : PTR_W'(idx_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = msg.msg_last ? SHOW : LOAD;
        LOAD:    if (load_done) state_next = SHOW;
        SHOW:    state_next = SHOW;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready    = 1'b1;
    busy     = (state != IDLE);
    digit    = 4'hF;
    abcdefgh = 8'hFF;
    if (state == SHOW) begin
      ready = 1'b0;
      digit = ~scan;
      if (len > LEN_W'(4))             abcdefgh = msg_buf[idx];
      else if (LEN_W'(pos) < len)      abcdefgh = msg_buf[PTR_W'(pos)];
    end
  end

  // Scan and frame counting run in every state; clear leaves them alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      scan      <= 4'b1000;
      frame_cnt <= '0;
      wr_ptr    <= '0;
      len       <= '0;
      offset    <= '0;
    end else begin
      div_cnt <= div_cnt + SCAN_DIV_W'(1);
      if (scan_tick) scan <= {scan[0], scan[3:1]};
      if (frame_end) frame_cnt <= scroll_step ? '0 : frame_cnt + FC_W'(1);
      if (clear) begin
        wr_ptr <= '0;
        len    <= '0;
        offset <= '0;
      end else if (accept) begin
        if (state == IDLE) begin
          wr_ptr <= PTR_W'(1);
          if (msg.msg_last) len <= LEN_W'(1);
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (load_done) begin
            len       <= LEN_W'(wr_ptr) + LEN_W'(1);
            offset    <= '0;
            frame_cnt <= '0;
          end
        end
      end else if ((state == SHOW) && scroll_step && scroll_en && (len > LEN_W'(4))) begin
        offset <= (LEN_W'(offset) == len - LEN_W'(1)) ? '0 : offset + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) msg_buf[wr_idx] <= msg.msg_data;
  end
endmodule
